serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor. It is the inverse-operation companion to the team's ripple-carry adder datapath. Operands are latched on a start pulse and processed LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow. Difference, borrow-out and signed overflow are presented with a one-cycle done pulse. The block is for area-constrained paths where a multi-cycle subtract is acceptable.

---
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor. Operands are captured on a start request
// taken in IDLE and are then processed LSB-first, one bit per clock, through a
// single full-subtractor cell with a registered borrow. When the last bit has
// been processed, the difference, borrow-out and signed overflow are loaded
// into output registers and done pulses for one cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (aborts any operation in flight)
//   start  in   operation request, sampled only in IDLE
//   a      in   WIDTH-bit minuend
//   b      in   WIDTH-bit subtrahend
//   bin    in   borrow-in
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse; d/bout/ovf are valid from this cycle on
//   d      out  WIDTH-bit difference, held until the next completion
//   bout   out  borrow-out (unsigned underflow)
//   ovf    out  signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;      // minuend, shifted right each SHIFT cycle
  logic [WIDTH-1:0] b_q;      // subtrahend, shifted right each SHIFT cycle
  logic [WIDTH-1:0] res_q;    // partial difference, filled from the MSB end
  logic             br_q;     // borrow into the current bit
  logic [CW-1:0]    cnt_q;    // index of the bit being processed
  logic             sa_q;     // sign of a captured at start
  logic             sb_q;     // sign of b captured at start
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;

  // Full-subtractor cell on the current LSBs.
  logic             diff_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  assign diff_d = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d   = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
  // After WIDTH shifts the first-processed bit (LSB) has reached bit 0.
  assign res_d  = {diff_d, res_q[WIDTH-1:1]};

  // NOTE: all state lives in one clocked block using non-blocking assignments,
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sa_q    <= a[WIDTH-1];
            sb_q    <= b[WIDTH-1];
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // Last bit: diff_d is the result sign bit.
            d_q     <= res_d;
            bout_q  <= br_d;
            ovf_q   <= (sa_q != sb_q) && (diff_d != sa_q);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed-vector bench for serial_subtractor (WIDTH=8). Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge. Edge k is the
// rising edge at which start is sampled in IDLE; done must be high after edge
// k+8 with busy high after edges k..k+7.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request so that it is sampled at the next rising edge (edge k);
  // returns 1 ns after edge k with start deasserted.
  task automatic issue_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic binv);
    @(negedge clk);
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 'x;
    b     = 'x;
    bin   = 1'bx;
  endtask

  // Called 1 ns after edge k. Counts busy samples before done, the edge offset
  // at which done appears (-1 on timeout), whether d moved while waiting, and
  // whether busy and done were ever seen together.
  task automatic run_to_done(input logic [W-1:0] held, output int lat,
                             output int busy_n, output bit held_bad,
                             output bit overlap);
    lat      = -1;
    busy_n   = 0;
    held_bad = 1'b0;
    overlap  = 1'b0;
    if (busy) busy_n++;
    if (busy && done) overlap = 1'b1;
    if (d !== held) held_bad = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_n++;
      if (d !== held) held_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #2;
    total++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL power_on_reset: got busy=%b done=%b d=%h bout=%b ovf=%b want all 0",
               busy, done, d, bout, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b d=%h want all 0", busy, done, d);
    end
  endtask

  task automatic test_basic();
    int lat, busy_n;
    bit held_bad, overlap;
    issue_start(8'h5A, 8'h23, 1'b0);
    run_to_done(8'h00, lat, busy_n, held_bad, overlap);
    total++;
    if (lat != W) begin
      bad++;
      $display("FAIL basic_latency: got done at edge k+%0d want k+%0d", lat, W);
    end
    total++;
    if (busy_n != W) begin
      bad++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", busy_n, W);
    end
    total++;
    if ({d, bout, ovf, busy} !== {8'h37, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_result: got d=%h bout=%b ovf=%b busy=%b want d=37 bout=0 ovf=0 busy=0",
               d, bout, ovf, busy);
    end
    total++;
    if (held_bad || overlap) begin
      bad++;
      $display("FAIL basic_hold_overlap: got held_bad=%b overlap=%b want 0 0", held_bad, overlap);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || d !== 8'h37) begin
      bad++;
      $display("FAIL basic_done_pulse: got done=%b d=%h want done=0 d=37", done, d);
    end
  endtask

  task automatic test_idle_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL idle_async_reset: got busy=%b done=%b d=%h bout=%b ovf=%b want all 0",
               busy, done, d, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Back-to-back vectors covering unsigned underflow, borrow-in and signed
  // overflow. Each starts at the earliest legal edge after the previous done.
  task automatic test_vectors();
    logic [W-1:0] va [5] = '{8'h00, 8'h10, 8'h80, 8'h7F, 8'hFF};
    logic [W-1:0] vb [5] = '{8'h01, 8'h10, 8'h01, 8'hFF, 8'hFF};
    logic         vi [5] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    logic [W-1:0] ed [5] = '{8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h00};
    logic         eb [5] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic         eo [5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    logic [W-1:0] prev;
    int lat, busy_n;
    bit held_bad, overlap;
    prev = 8'h00;
    for (int i = 0; i < 5; i++) begin
      issue_start(va[i], vb[i], vi[i]);
      run_to_done(prev, lat, busy_n, held_bad, overlap);
      total++;
      if (lat != W || busy_n != W || held_bad || overlap) begin
        bad++;
        $display("FAIL vec%0d_timing: got lat=%0d busy=%0d held_bad=%b overlap=%b want %0d %0d 0 0",
                 i, lat, busy_n, held_bad, overlap, W, W);
      end
      total++;
      if ({d, bout, ovf} !== {ed[i], eb[i], eo[i]}) begin
        bad++;
        $display("FAIL vec%0d_result a=%h b=%h bin=%b: got d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
                 i, va[i], vb[i], vi[i], d, bout, ovf, ed[i], eb[i], eo[i]);
      end
      prev = ed[i];
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_done_pulse: got done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones, done_at;
    bit held_bad, overlap, late_busy;
    logic [W-1:0] d_at_done;
    // Previous result is 0x00 from the last vector.
    issue_start(8'h05, 8'h03, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);            // edge k+3
    #1;
    start = 1'b0;
    dones     = 0;
    done_at   = -1;
    held_bad  = 1'b0;
    overlap   = 1'b0;
    late_busy = 1'b0;
    d_at_done = 'x;
    for (int i = 4; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        dones++;
        if (done_at < 0) begin
          done_at   = i;
          d_at_done = d;
        end
      end
      if (done_at < 0 && !done && d !== 8'h00) held_bad = 1'b1;
      if (done_at >= 0 && busy) late_busy = 1'b1;
    end
    total++;
    if (dones != 1 || done_at != W) begin
      bad++;
      $display("FAIL ignored_start_done: got dones=%0d at k+%0d want 1 at k+%0d", dones, done_at, W);
    end
    total++;
    if (d_at_done !== 8'h02 || d !== 8'h02) begin
      bad++;
      $display("FAIL ignored_start_result: got d=%h (final %h) want 02", d_at_done, d);
    end
    total++;
    if (held_bad || overlap || late_busy) begin
      bad++;
      $display("FAIL ignored_start_hold: got held_bad=%b overlap=%b late_busy=%b want 0 0 0",
               held_bad, overlap, late_busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, busy_n, dones;
    bit held_bad, overlap;
    issue_start(8'h5A, 8'h23, 1'b0);
    repeat (3) @(posedge clk);  // edge k+3: 4th SHIFT cycle follows
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL midop_reset: got busy=%b done=%b d=%h bout=%b ovf=%b want all 0",
               busy, done, d, bout, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    total++;
    if (dones != 0 || d !== 8'h00) begin
      bad++;
      $display("FAIL midop_no_done: got active_samples=%0d d=%h want 0 and 00", dones, d);
    end
    issue_start(8'h09, 8'h04, 1'b0);
    run_to_done(8'h00, lat, busy_n, held_bad, overlap);
    total++;
    if (lat != W || busy_n != W || held_bad || overlap) begin
      bad++;
      $display("FAIL midop_restart_timing: got lat=%0d busy=%0d held_bad=%b overlap=%b want %0d %0d 0 0",
               lat, busy_n, held_bad, overlap, W, W);
    end
    total++;
    if ({d, bout, ovf} !== {8'h05, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midop_restart_result: got d=%h bout=%b ovf=%b want d=05 bout=0 ovf=0",
               d, bout, ovf);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_idle_reset();
    test_vectors();
    test_ignored_start();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
